// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues i_cache line reads and buffers the
// returned words with their PCs in a circular queue feeding decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 16
) (
    input  logic                   i_clk,
    input  logic                   rst,
    output logic [31:0]            cache_pc,
    output logic                   cache_rd_en,
    output logic                   cache_abort,
    input  logic [127:0]           cache_dout,
    input  logic                   cache_dout_valid,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic [$clog2(DEPTH):0] queue_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [31:2]     fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rd_en_q, abort_q, valid_q;

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem [DEPTH];

    logic            push, pop;
    logic [1:0]      off;
    logic [2:0]      push_n;
    logic [3:0]      wr_en;
    logic [AW-1:0]   wr_idx [4];
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    always_comb begin
        off    = fetch_pc_q[3:2];
        push   = (state_q == REQ) && cache_dout_valid
                 && !redirect_valid && !rst;
        pop    = valid_q && instr_ready && !redirect_valid;
        push_n = push ? (3'd4 - {1'b0, off}) : 3'd0;
        // Words below the fetch offset belong to an earlier PC and are dropped
        for (int k = 0; k < 4; k++) begin
            wr_en[k]  = push && (2'(k) >= off);
            wr_idx[k] = wr_ptr_q + AW'(k) - AW'(off);
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            state_d    = (state_q == REQ) ? ABORT : IDLE;
            fetch_pc_d = redirect_pc[31:2];
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q <= CW'(DEPTH - 4)) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (cache_dout_valid) begin
                        state_d    = IDLE;
                        fetch_pc_d = {fetch_pc_q[31:4] + 28'd1, 2'b00};
                    end
                end
                ABORT:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_n);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push_n) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC[31:2];
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_en_q    <= 1'b0;
            abort_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_en_q    <= (state_d == REQ);
            abort_q    <= (state_d == ABORT);
            valid_q    <= (count_d != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
                instr_mem[wr_idx[k]] <= cache_dout[32*k +: 32];
                pc_mem[wr_idx[k]]    <= {fetch_pc_q[31:4], 2'(k), 2'b00};
            end
        end
    end

    assign cache_pc    = {fetch_pc_q[31:4], 4'h0};
    assign cache_rd_en = rd_en_q;
    assign cache_abort = abort_q;
    assign instr_valid = valid_q;
    assign queue_count = count_q;
    assign instr       = instr_mem[rd_ptr_q];
    assign instr_pc    = pc_mem[rd_ptr_q];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized checks of fetch_unit against a queue-level
// behavioural model of the fetch request / line split / flush rules.
module tb_fetch_unit;
    localparam int          DEPTH = 16;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, rd_en, abort, dv, rdr, ivalid, irdy;
    logic [31:0]  cache_pc, rpc, instr, ipc;
    logic [127:0] dout;
    logic [4:0]   qcount;

    logic         rst5, rd5, ab5, dv5, iv5, rdr5, rdy5;
    logic [31:0]  pc5, rpc5, in5, ip5;
    logic [127:0] dout5;
    logic [4:0]   qc5;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) u_dut (
        .i_clk(clk), .rst(rst),
        .cache_pc(cache_pc), .cache_rd_en(rd_en),
        .cache_abort(abort), .cache_dout(dout),
        .cache_dout_valid(dv), .redirect_valid(rdr),
        .redirect_pc(rpc), .instr_valid(ivalid),
        .instr_ready(irdy), .instr(instr),
        .instr_pc(ipc), .queue_count(qcount)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF0), .DEPTH(DEPTH)) u_wrap (
        .i_clk(clk), .rst(rst5),
        .cache_pc(pc5), .cache_rd_en(rd5),
        .cache_abort(ab5), .cache_dout(dout5),
        .cache_dout_valid(dv5), .redirect_valid(rdr5),
        .redirect_pc(rpc5), .instr_valid(iv5),
        .instr_ready(rdy5), .instr(in5),
        .instr_pc(ip5), .queue_count(qc5)
    );

    logic [63:0] mq[$];
    logic [31:0] mpc;
    bit          mreq, mabort;
    int          ncmp = 0;
    int          nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all();
        chk("rd_en", 64'(rd_en), 64'(mreq));
        chk("abort", 64'(abort), 64'(mabort));
        chk("count", 64'(qcount), 64'(mq.size()));
        chk("valid", 64'(ivalid), 64'(mq.size() != 0));
        chk("cache_pc", 64'(cache_pc), 64'({mpc[31:4], 4'h0}));
        if (mq.size() != 0) begin
            chk("head_instr", 64'(instr), 64'(mq[0][31:0]));
            chk("head_pc", 64'(ipc), 64'(mq[0][63:32]));
        end
    endtask

    // One clock: drive inputs, advance the model, then compare.
    task automatic step(input bit r, input bit rd, input logic [31:0] rp,
                        input bit rdy, input bit d,
                        input logic [127:0] line);
        int cnt0;
        rst = r; rdr = rd; rpc = rp; irdy = rdy; dv = d; dout = line;
        cnt0 = mq.size();
        if (r) begin
            mq.delete();
            mpc = RPC; mreq = 0; mabort = 0;
        end else if (rd) begin
            mabort = mreq; mreq = 0;
            mq.delete();
            mpc = {rp[31:2], 2'b00};
        end else begin
            if (rdy && cnt0 > 0) void'(mq.pop_front());
            if (mabort) begin
                mabort = 0;
            end else if (mreq) begin
                if (d) begin
                    for (int k = int'(mpc[3:2]); k < 4; k++)
                        mq.push_back({mpc[31:4], 2'(k), 2'b00,
                                      line[32*k +: 32]});
                    mpc = {mpc[31:4] + 28'd1, 4'h0};
                    mreq = 0;
                end
            end else begin
                mreq = (cnt0 <= DEPTH - 4);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [127:0] ln;
        rst = 1; rdr = 0; rpc = 0; irdy = 0; dv = 0; dout = '0;
        rst5 = 1; rdr5 = 0; rpc5 = 0; rdy5 = 0; dv5 = 0; dout5 = '0;
        mpc = RPC; mreq = 0; mabort = 0;

        // T5: line address wraps from the top of memory
        @(posedge clk); @(negedge clk);
        rst5 = 0;
        for (int i = 0; i < 8 && !rd5; i++) @(negedge clk);
        chk("t5_req", 64'(rd5), 64'd1);
        chk("t5_pc", 64'(pc5), 64'hFFFF_FFF0);
        dout5 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        dv5 = 1;
        @(posedge clk); @(negedge clk);
        dv5 = 0;
        chk("t5_wrap", 64'(pc5), 64'h0);
        chk("t5_count", 64'(qc5), 64'd4);
        chk("t5_head_pc", 64'(ip5), 64'hFFFF_FFF0);
        chk("t5_head", 64'(in5), 64'h1111_1111);

        // Reset state
        step(1, 0, 0, 0, 0, '0);
        chk("rst_count", 64'(qcount), 64'd0);
        chk("rst_pc", 64'(cache_pc), 64'h100);

        // T1: two cycles of latency, words A..D
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        ln = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
        step(0, 0, 0, 0, 1, ln);
        chk("t1_count", 64'(qcount), 64'd4);
        chk("t1_head", 64'(instr), 64'hAAAA_AAAA);
        chk("t1_head_pc", 64'(ipc), 64'h100);
        chk("t1_next_pc", 64'(cache_pc), 64'h110);

        // T2: fill to DEPTH, request only once 4 slots are free
        for (int i = 0; i < 40 && mq.size() < DEPTH; i++)
            step(0, 0, 0, 0, mreq, rnd_line());
        chk("t2_full", 64'(qcount), 64'd16);
        repeat (3) step(0, 0, 0, 0, 0, '0);
        chk("t2_hold", 64'(rd_en), 64'd0);
        repeat (4) step(0, 0, 0, 1, 0, '0);
        chk("t2_hold12", 64'(rd_en), 64'd0);
        step(0, 0, 0, 0, 0, '0);
        chk("t2_req", 64'(rd_en), 64'd1);

        // T3: redirect while a read is outstanding
        step(0, 1, 32'h208, 0, 0, '0);
        chk("t3_abort", 64'(abort), 64'd1);
        chk("t3_count", 64'(qcount), 64'd0);
        chk("t3_pc", 64'(cache_pc), 64'h200);
        step(0, 0, 0, 0, 0, '0);
        chk("t3_abort_end", 64'(abort), 64'd0);
        step(0, 0, 0, 0, 0, '0);
        ln = rnd_line();
        step(0, 0, 0, 0, 1, ln);
        chk("t3_count2", 64'(qcount), 64'd2);
        chk("t3_pc0", 64'(ipc), 64'h208);
        chk("t3_w2", 64'(instr), 64'(ln[95:64]));
        step(0, 0, 0, 1, 0, '0);
        chk("t3_pc1", 64'(ipc), 64'h20C);
        chk("t3_w3", 64'(instr), 64'(ln[127:96]));

        // T4: push and pop on the same edge at count 12
        for (int i = 0; i < 40 && mq.size() != 13; i++)
            step(0, 0, 0, 0, mreq, rnd_line());
        chk("t4_13", 64'(qcount), 64'd13);
        step(0, 0, 0, 1, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        chk("t4_req", 64'(rd_en), 64'd1);
        chk("t4_12", 64'(qcount), 64'd12);
        step(0, 0, 0, 1, 1, rnd_line());
        chk("t4_15", 64'(qcount), 64'd15);
        repeat (16) step(0, 0, 0, 1, 0, '0);

        // T6: reset wins over a returning line
        for (int i = 0; i < 10 && !mreq; i++)
            step(0, 0, 0, 0, 0, '0);
        chk("t6_req", 64'(rd_en), 64'd1);
        step(1, 0, 0, 0, 1, rnd_line());
        chk("t6_count", 64'(qcount), 64'd0);
        chk("t6_valid", 64'(ivalid), 64'd0);
        chk("t6_rd_en", 64'(rd_en), 64'd0);
        chk("t6_pc", 64'(cache_pc), 64'h100);

        // Random traffic: stray dout_valid, redirects, resets, back-pressure
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 30) == 0, $urandom,
                 ($urandom % 3) != 0, ($urandom % 3) == 0, rnd_line());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule
